// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-requester round-robin sequencer in front of one single-port
//   synchronous RAM. Each requester's read/write command is latched in IDLE
//   and issued to the RAM in ISSUE. A read then spends one cycle in WAIT
//   while the RAM data comes back. The data is returned to the requester
//   that issued the read, together with a one-cycle valid pulse.
//
//   Ports
//     clk, rst_n                      system clock, async active-low reset
//     req/we/addr/wdata{0,1}          requester commands, held until gnt
//     gnt{0,1}                        1-cycle pulse while the command issues
//     rvalid{0,1}, rdata{0,1}         read return pulse and held read data
//     ram_en/we/addr/wdata, ram_rdata RAM control and data pins
//     busy                            FSM not in IDLE
//     last_grant                      id of the most recently granted requester

// Per-requester read-return slice. It captures RAM data when the
// sequencer's WAIT cycle belongs to this requester. It holds the data
// until that requester's next read completes.
module ram_port_arbiter_rsp #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= cap;
      if (cap) rdata <= ram_rdata;
    end
  end
endmodule

module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  last_grant
);
  localparam int NUM_REQ = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  typedef struct packed {
    logic                  id;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  logic [NUM_REQ-1:0]                 req_v, we_v, gnt_v, rvalid_v;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v, rdata_v;

  assign req_v   = {req1, req0};
  assign we_v    = {we1, we0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};

  logic [1:0] state;
  logic       ptr;   // requester favoured on contention
  logic       win;
  cmd_t       cmd;

  // A lone requester wins outright. Under contention the pointer decides.
  assign win = (&req_v) ? ptr : req_v[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= 1'b0;
      cmd   <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req_v) begin
          cmd   <= '{id: win, we: we_v[win], addr: addr_v[win], wdata: wdata_v[win]};
          ptr   <= ~win;
          state <= S_ISSUE;
        end
        S_ISSUE: state <= cmd.we ? S_IDLE : S_WAIT;
        S_WAIT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ram_en/ram_we decode straight from the state, so a reset drops them at
  // once. Address and data come from the latched command and hold between
  // accesses.
  assign ram_en     = (state == S_ISSUE);
  assign ram_we     = ram_en & cmd.we;
  assign ram_addr   = cmd.addr;
  assign ram_wdata  = cmd.wdata;
  assign busy       = (state != S_IDLE);
  assign last_grant = cmd.id;

  assign gnt_v = ram_en ? (cmd.id ? 2'b10 : 2'b01) : 2'b00;
  assign gnt0  = gnt_v[0];
  assign gnt1  = gnt_v[1];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    ram_port_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap       ((state == S_WAIT) && (cmd.id == 1'(i))),
      .ram_rdata (ram_rdata),
      .rvalid    (rvalid_v[i]),
      .rdata     (rdata_v[i])
    );
  end

  assign rvalid0 = rvalid_v[0];
  assign rvalid1 = rvalid_v[1];
  assign rdata0  = rdata_v[0];
  assign rdata1  = rdata_v[1];
endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy, last_grant;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .last_grant(last_grant)
  );

  // Behavioural single-port synchronous RAM, 16 x 8.
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ram_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Mutual exclusion of grants and returns, checked every cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total_cnt++;
      assert (!((gnt0 && gnt1) || (rvalid0 && rvalid1))) pass_cnt++;
      else $error("FAIL excl gnt=%b%b rvalid=%b%b required not both", gnt1, gnt0, rvalid1, rvalid0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic we, input logic [3:0] a, input logic [7:0] d);
    if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic do_write(input int id, input logic [3:0] a, input logic [7:0] d);
    set_req(id, 1'b1, a, d);
    step();
    chk("wr_gnt", {30'd0, gnt1, gnt0}, (id == 0) ? 32'd1 : 32'd2);
    chk("wr_ram", {22'd0, ram_en, ram_we, ram_addr, ram_wdata}, {22'd0, 2'b11, a, d});
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("wr_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_read(input int id, input logic [3:0] a, input logic [7:0] exp);
    set_req(id, 1'b0, a, 8'h00);
    step();
    chk("rd_gnt", {30'd0, gnt1, gnt0}, (id == 0) ? 32'd1 : 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    chk("rd_rvalid", {30'd0, rvalid1, rvalid0}, (id == 0) ? 32'd1 : 32'd2);
    chk("rd_data", {24'd0, (id == 0) ? rdata0 : rdata1}, {24'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    #22;
    chk("reset_outs", {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_en, ram_we,
                       ram_addr, ram_wdata, busy, last_grant}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      chk("idle", {26'd0, ram_en, busy, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
      step();
    end

    // Write 0x5A to addr 3 from requester 0.
    set_req(0, 1'b1, 4'd3, 8'h5A);
    step();
    chk("w_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    chk("w_ram", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 4'd3, 8'h5A});
    chk("w_busy_lg", {busy, last_grant}, 2'b10);
    req0 = 1'b0;
    step();
    chk("w_back_idle", {busy, gnt0, ram_en, ram_we}, 4'b0000);
    chk("w_addr_hold", {ram_addr, ram_wdata}, {4'd3, 8'h5A});

    // Requester 1 reads addr 3 and sees the new data.
    set_req(1, 1'b0, 4'd3, 8'h00);
    step();
    chk("raw_gnt", {gnt1, gnt0, ram_en, ram_we, last_grant}, 5'b10101);
    req1 = 1'b0;
    step();
    chk("raw_wait", {busy, rvalid1}, 2'b10);
    step();
    chk("raw_rvalid", {busy, rvalid1, rvalid0}, 3'b010);
    chk("raw_rdata1", rdata1, 8'h5A);
    chk("raw_rdata0", rdata0, 8'h00);
    step();
    chk("raw_hold", {rvalid1, rdata1}, {1'b0, 8'h5A});

    // Seed addr 1/2 for contention; pointer ends back at requester 0.
    do_write(0, 4'd1, 8'h11);
    do_write(1, 4'd2, 8'h22);
    chk("wr_no_rdata", {rvalid0, rvalid1, rdata0, rdata1}, {2'b00, 8'h00, 8'h5A});

    // Contention: both hold reads continuously, grants alternate.
    set_req(0, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b0, 4'd2, 8'h00);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("cont_gnt", {30'd0, gnt1, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      step();
      chk("cont_rvalid", {30'd0, rvalid1, rvalid0}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_rdata", (k % 2 == 0) ? rdata0 : rdata1, (k % 2 == 0) ? 8'h11 : 8'h22);
      if (k == 5) begin req0 = 1'b0; req1 = 1'b0; end
    end
    step();
    chk("cont_done", {busy, gnt0, gnt1}, 3'b000);

    // Withdraw: req0 pulsed for one cycle while FSM is in WAIT.
    set_req(1, 1'b0, 4'd2, 8'h00);
    step();
    chk("wd_gnt1", {gnt1, gnt0}, 2'b10);
    req1 = 1'b0;
    step();
    set_req(0, 1'b0, 4'd1, 8'h00);
    step();
    req0 = 1'b0;
    chk("wd_rvalid1", {rvalid1, rdata1}, {1'b1, 8'h22});
    step();
    chk("wd_no_gnt", {gnt0, gnt1, busy}, 3'b000);
    step();
    chk("wd_no_gnt2", {gnt0, gnt1, busy}, 3'b000);

    // Reset during WAIT of a requester-0 read (pointer then at 1).
    set_req(0, 1'b0, 4'd1, 8'h00);
    step();
    chk("rst_gnt0", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    step();
    chk("rst_in_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {ram_en, ram_we, busy, rvalid0, rvalid1}, 5'b00000);
    step();
    chk("rst_no_rvalid", {rvalid0, rvalid1, rdata0}, {2'b00, 8'h00});
    rst_n = 1'b1;
    step();
    set_req(0, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b0, 4'd2, 8'h00);
    step();
    chk("rst_ptr0", {gnt1, gnt0, last_grant}, 3'b010);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    chk("rst_rd", {rvalid0, rvalid1, rdata0}, {2'b10, 8'h11});

    // Address wrap: top and bottom addresses are distinct.
    do_write(0, 4'd15, 8'hFF);
    do_write(1, 4'd0, 8'h01);
    do_read(0, 4'd15, 8'hFF);
    do_read(1, 4'd0, 8'h01);
    chk("wrap_rdata0", rdata0, 8'hFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the board's single-port synchronous RAM (16 x 8 by default). The switch/key write path and the hex-display scan path both need the same RAM. This block serialises their read/write commands, drives the RAM control pins, and returns read data with a valid pulse to the requester that issued the read. It sits between the requesters and one RAM instance, and everything runs on the system clock.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 4, RAM address width (2**ADDR_WIDTH words)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 command request; hold until gnt0
we0  input  1  requester 0: 1=write, 0=read
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
gnt0  output  1  1-cycle pulse: requester 0 command is being issued
rvalid0  output  1  1-cycle pulse: rdata0 holds requester 0 read result
rdata0  output  DATA_WIDTH  last read result for requester 0, held
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
ram_en  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_rdata  input  DATA_WIDTH  RAM read data, valid 1 cycle after a read-enabled edge
busy  output  1  1 when the FSM is not in IDLE
last_grant  output  1  id of the most recently granted requester

Behaviour:
- Reset (asynchronous, rst_n=0): FSM=IDLE; all outputs 0; priority pointer=0 (requester 0 favoured); latched command cleared. Release is sampled on the next clk edge.
- FSM states:
  - IDLE: if any req, pick a winner, latch {id, we, addr, wdata}, go to ISSUE. If no req, stay in IDLE.
  - ISSUE: ram_en=1, ram_we=latched we, ram_addr/ram_wdata=latched values; gnt<id>=1 for this cycle only. Next state is WAIT for a read, IDLE for a write.
  - WAIT: ram_rdata is valid; capture it into rdata<id> at the end of the cycle; go to IDLE.
- Timing, with req sampled in cycle T:
  - gnt pulses in T+1.
  - A write lands at the T+1 edge.
  - For a read, rvalid<id>=1 in T+3 with rdata<id> already updated. The FSM is back in IDLE in T+3 and may arbitrate again in that same cycle.
  - Throughput: write 1 per 2 cycles, read 1 per 3 cycles.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the requester the pointer favours wins.
  - After every grant, the pointer moves to the other requester. Continuous requesters therefore alternate strictly, and neither waits more than one command.
- Handshake:
  - A requester keeps req/we/addr/wdata stable from assertion until the cycle its gnt is high.
  - The arbiter samples inputs only in IDLE. Changes at any other time are ignored.
  - Deasserting req before gnt withdraws the request with no side effect.
- Output registers:
  - ram_en/ram_we are 0 outside ISSUE.
  - ram_addr/ram_wdata hold their last values.
  - rdata0/rdata1 hold until that requester's next read completes.
  - A write never changes rdata or rvalid.
- Ordering: commands take effect in grant order. A write by one requester followed by a read of the same address by the other returns the new data.
- Address wrap: no range checks are needed because all ADDR_WIDTH values are legal.
- Reset mid-operation: an in-flight command is abandoned, no rvalid is produced, and ram_en/ram_we drop to 0 immediately. A write in ISSUE takes effect only if the clk edge precedes the reset assertion.
- gnt0 and gnt1 are never high together, and rvalid0 and rvalid1 are never high together.
- last_grant updates in the ISSUE cycle.

Test Plan:
- Reset, then idle with req0=req1=0 for 10 cycles -> all outputs 0, busy=0, ram_en never high.
- Write: req0=1, we0=1, addr0=3, wdata0=0x5A -> gnt0 pulses 1 cycle after req, ram_en=ram_we=1, ram_addr=3, ram_wdata=0x5A in that cycle; FSM back in IDLE the cycle after.
- Read-after-write: req1 read addr 3 after the write -> rvalid1 pulses 3 cycles after req1 sampled with rdata1=0x5A; rdata0 unchanged.
- Contention: req0 and req1 both held continuously for 6 reads (addr0=1, addr1=2) -> grants alternate 0,1,0,1,0,1 starting with requester 0 after reset; each rvalid is paired with the correct id and data.
- Withdraw and reset:
  - req0 pulsed for 1 cycle while the FSM is in WAIT -> no gnt0.
  - rst_n asserted during WAIT -> no rvalid; pointer back to 0; next simultaneous request is granted to requester 0.
- Wrap: write 0xFF to addr 15 and 0x01 to addr 0, then read both -> 0xFF and 0x01 with no aliasing.
